// File: rtl/rx_sample_packer.sv
// rx_sample_packer
// Packs I/Q sample pairs into fixed-length packets of 18-bit words for the RX
// dual-clock FIFO. A packet is started only when the FIFO can hold all of it.
// Otherwise the whole packet is dropped and counted, so the FIFO never holds a
// partial packet.
// Word format: [15:0] data, [16] start-of-packet, [17] end-of-packet.
// Ports:
//   clock, reset_n       clock (FIFO write clock), synchronous active-low reset
//   clear                synchronous abort to IDLE (issued together with FIFO aclr)
//   enable               packing enable, sampled only at packet boundaries
//   strobe               one-cycle qualifier for sample_i / sample_q
//   sample_i, sample_q   16-bit I and Q samples
//   fifo_data, fifo_wrreq  word and write request to the FIFO
//   fifo_usedw, fifo_full  FIFO write-side fill level and full flag
//   overrun              one-cycle pulse per lost sample or dropped packet
//   drop_count           saturating count of dropped packets
module rx_sample_packer #(
    parameter int unsigned PKT_SAMPLES = 128,
    parameter int unsigned FIFO_DEPTH  = 4096,
    parameter int unsigned USEDW_BITS  = 12,
    parameter int unsigned HEADROOM    = 4,
    parameter int unsigned DROP_BITS   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  strobe,
    input  logic [15:0]           sample_i,
    input  logic [15:0]           sample_q,
    output logic [17:0]           fifo_data,
    output logic                  fifo_wrreq,
    input  logic [USEDW_BITS-1:0] fifo_usedw,
    input  logic                  fifo_full,
    output logic                  overrun,
    output logic [DROP_BITS-1:0]  drop_count
);

    localparam int unsigned PKT_WORDS = 2 * PKT_SAMPLES;
    localparam int unsigned CNT_W     = $clog2(PKT_SAMPLES);
    localparam int unsigned ROOM_W    = USEDW_BITS + 1;

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PKT_SAMPLES - 1);
    localparam logic [ROOM_W-1:0] NEED      = ROOM_W'(PKT_WORDS + HEADROOM);
    localparam logic [ROOM_W-1:0] DEPTH     = ROOM_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR_Q,
        MID,
        DROP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        q_hold;
    logic [ROOM_W-1:0]  room_c;
    logic               room_ok_c;
    logic               last_c;

    // Free space; usedw wraps to 0 when full, so full forces zero room.
    assign room_c    = fifo_full ? '0 : (DEPTH - {1'b0, fifo_usedw});
    assign room_ok_c = (room_c >= NEED);
    assign last_c    = (cnt == LAST_CNT);

    // Packet FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            q_hold     <= '0;
            fifo_data  <= '0;
            fifo_wrreq <= 1'b0;
            overrun    <= 1'b0;
            drop_count <= '0;
        end else begin
            fifo_wrreq <= 1'b0;
            overrun    <= 1'b0;
            if (clear) begin
                // Abandon any partial packet; drop_count is kept.
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (strobe && enable) begin
                            if (room_ok_c) begin
                                fifo_data  <= {1'b0, 1'b1, sample_i};
                                fifo_wrreq <= 1'b1;
                                q_hold     <= sample_q;
                                state      <= WR_Q;
                            end else begin
                                overrun <= 1'b1;
                                if (drop_count != '1) begin
                                    drop_count <= drop_count + DROP_BITS'(1);
                                end
                                cnt   <= CNT_W'(1);
                                state <= DROP;
                            end
                        end
                    end
                    WR_Q: begin
                        // A strobe here is lost; the packet keeps its length.
                        fifo_data  <= {last_c, 1'b0, q_hold};
                        fifo_wrreq <= 1'b1;
                        overrun    <= strobe;
                        if (last_c) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= MID;
                        end
                    end
                    MID: begin
                        if (strobe) begin
                            fifo_data  <= {2'b00, sample_i};
                            fifo_wrreq <= 1'b1;
                            q_hold     <= sample_q;
                            state      <= WR_Q;
                        end
                    end
                    DROP: begin
                        // Swallow the rest of the dropped packet silently.
                        if (strobe) begin
                            if (last_c) begin
                                cnt   <= '0;
                                state <= IDLE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_sample_packer.sv
// Scoreboard bench for rx_sample_packer. A second instance with an 8-bit drop
// counter shares all inputs so drop-count saturation is reachable quickly.
module tb_rx_sample_packer;

    localparam int PKT = 128;

    logic        clock = 1'b0;
    logic        reset_n, clear, enable, strobe;
    logic [15:0] sample_i, sample_q;
    logic [11:0] fifo_usedw;
    logic        fifo_full;

    logic [17:0] fifo_data,  fifo_data_s;
    logic        fifo_wrreq, fifo_wrreq_s;
    logic        overrun,    overrun_s;
    logic [15:0] drop_count;
    logic [7:0]  drop_count_s;

    int errors = 0;
    int checks = 0;
    int ovr_seen = 0;
    int ovr_seen_s = 0;
    int writes_seen = 0;
    int exp_drop = 0;
    int exp_ovr = 0;
    logic mon_en = 1'b0;
    logic [17:0] exp_q[$];

    always #5 clock = ~clock;

    rx_sample_packer u_dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
        .strobe(strobe), .sample_i(sample_i), .sample_q(sample_q),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq),
        .fifo_usedw(fifo_usedw), .fifo_full(fifo_full),
        .overrun(overrun), .drop_count(drop_count)
    );

    rx_sample_packer #(.DROP_BITS(8)) u_sat (
        .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
        .strobe(strobe), .sample_i(sample_i), .sample_q(sample_q),
        .fifo_data(fifo_data_s), .fifo_wrreq(fifo_wrreq_s),
        .fifo_usedw(fifo_usedw), .fifo_full(fifo_full),
        .overrun(overrun_s), .drop_count(drop_count_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [17:0] iw(input int n);
        return {1'b0, (n == 0), 16'(n)};
    endfunction

    function automatic logic [17:0] qw(input int n);
        return {(n == PKT - 1), 1'b0, ~16'(n)};
    endfunction

    // Monitor: pop and compare whenever either instance writes.
    always @(negedge clock) begin
        if (mon_en) begin
            if (overrun === 1'b1) ovr_seen++;
            if (overrun_s === 1'b1) ovr_seen_s++;
            if (fifo_wrreq === 1'b1 || fifo_wrreq_s === 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data %0h, required no write", fifo_data);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("word", {14'b0, fifo_data}, {14'b0, e});
                    check("wrreq", {31'b0, fifo_wrreq}, 32'd1);
                    check("word_sat", {14'b0, fifo_data_s}, {14'b0, e});
                    check("wrreq_sat", {31'b0, fifo_wrreq_s}, 32'd1);
                end
                if (fifo_full) begin
                    checks++;
                    errors++;
                    $display("FAIL wrreq_while_full: got wrreq=1 full=1, required wrreq=0");
                end
            end
        end
    end

    task automatic pulse(input logic [15:0] i, input logic [15:0] q, input int gap);
        strobe   = 1'b1;
        sample_i = i;
        sample_q = q;
        @(negedge clock);
        strobe = 1'b0;
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic send_pkt(input int from, input int to);
        for (int n = from; n <= to; n++) begin
            exp_q.push_back(iw(n));
            exp_q.push_back(qw(n));
            pulse(16'(n), ~16'(n), 2);
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clock);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        reset_n = 1'b0; clear = 1'b0; enable = 1'b0; strobe = 1'b0;
        sample_i = '0; sample_q = '0; fifo_usedw = '0; fifo_full = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_data", {14'b0, fifo_data}, 32'd0);
        check("rst_wrreq", {31'b0, fifo_wrreq}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        check("rst_drop", {16'b0, drop_count}, 32'd0);
        check("rst_drop_sat", {24'b0, drop_count_s}, 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clock);

        // 1: full packet, with explicit latency check on the first sample
        enable = 1'b1;
        exp_q.push_back(iw(0));
        exp_q.push_back(qw(0));
        strobe = 1'b1; sample_i = 16'd0; sample_q = 16'hFFFF;
        @(negedge clock);
        strobe = 1'b0;
        check("lat_i_wrreq", {31'b0, fifo_wrreq}, 32'd1);
        check("lat_i_data", {14'b0, fifo_data}, 32'h10000);
        @(negedge clock);
        check("lat_q_wrreq", {31'b0, fifo_wrreq}, 32'd1);
        send_pkt(1, PKT - 1);
        drain("t1_all_words");
        check("t1_writes", writes_seen, 2 * PKT);
        check("t1_drop", {16'b0, drop_count}, 32'd0);
        check("t1_ovr", ovr_seen, 0);

        // 2: room 259 < 260 drops the whole packet
        fifo_usedw = 12'd3837;
        pulse(16'h1111, 16'h2222, 2);
        exp_drop++; exp_ovr++;
        check("t2_drop", {16'b0, drop_count}, exp_drop);
        check("t2_ovr_once", ovr_seen, exp_ovr);
        w0 = writes_seen;
        for (int k = 0; k < PKT - 1; k++) pulse(16'(k), 16'(k), 2);
        check("t2_no_writes", writes_seen - w0, 0);
        check("t2_ovr_still_once", ovr_seen, exp_ovr);
        fifo_usedw = 12'd0;
        exp_q.push_back(iw(0));
        exp_q.push_back(qw(0));
        pulse(16'd0, 16'hFFFF, 2);
        clear_pulse();
        drain("t2_sop_after_drop");

        // room exactly 260 is accepted
        fifo_usedw = 12'd3836;
        exp_q.push_back(iw(0));
        exp_q.push_back(qw(0));
        pulse(16'd0, 16'hFFFF, 2);
        clear_pulse();
        drain("t2_room_260");
        // full with usedw wrapped to 0 means no room
        fifo_usedw = 12'd0;
        fifo_full  = 1'b1;
        pulse(16'h3333, 16'h4444, 2);
        exp_drop++; exp_ovr++;
        check("t2_full_drop", {16'b0, drop_count}, exp_drop);
        fifo_full = 1'b0;
        clear_pulse();

        // 3: back-to-back strobe mid-packet loses the second sample
        send_pkt(0, 4);
        exp_q.push_back(iw(5));
        exp_q.push_back(qw(5));
        pulse(16'd5, ~16'd5, 1);
        pulse(16'hDEAD, 16'hBEEF, 2);
        exp_ovr++;
        send_pkt(6, PKT - 1);
        drain("t3_len");
        check("t3_ovr", ovr_seen, exp_ovr);

        // 4: disabled in IDLE, then enable dropped mid-packet
        enable = 1'b0;
        w0 = writes_seen;
        for (int k = 0; k < 3; k++) pulse(16'h5555, 16'h6666, 2);
        repeat (3) @(negedge clock);
        check("t4_disabled", writes_seen - w0, 0);
        enable = 1'b1;
        exp_q.push_back(iw(0));
        exp_q.push_back(qw(0));
        pulse(16'd0, 16'hFFFF, 2);
        enable = 1'b0;
        send_pkt(1, PKT - 1);
        drain("t4_completes");

        // 5: clear together with sample 40
        enable = 1'b1;
        send_pkt(0, 39);
        clear = 1'b1; strobe = 1'b1; sample_i = 16'd40; sample_q = ~16'd40;
        @(negedge clock);
        clear = 1'b0; strobe = 1'b0;
        check("t5_wrreq_after_clear", {31'b0, fifo_wrreq}, 32'd0);
        repeat (2) @(negedge clock);
        check("t5_idle_quiet", {31'b0, fifo_wrreq}, 32'd0);
        exp_q.push_back(iw(0));
        exp_q.push_back(qw(0));
        pulse(16'd0, 16'hFFFF, 2);
        clear_pulse();
        drain("t5_sop");
        check("t5_drop_kept", {16'b0, drop_count}, exp_drop);

        // 6: many drops saturate the narrow counter; reset clears both
        fifo_usedw = 12'd4000;
        for (int k = 0; k < 300; k++) begin
            strobe = 1'b1;
            @(negedge clock);
            strobe = 1'b0;
            clear  = 1'b1;
            @(negedge clock);
            clear  = 1'b0;
        end
        exp_drop += 300; exp_ovr += 300;
        repeat (2) @(negedge clock);
        check("t6_drop_wide", {16'b0, drop_count}, exp_drop);
        check("t6_drop_sat", {24'b0, drop_count_s}, 32'hFF);
        check("t6_ovr", ovr_seen, exp_ovr);
        check("t6_ovr_sat", ovr_seen_s, exp_ovr);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("t6_rst_drop", {16'b0, drop_count}, 32'd0);
        check("t6_rst_drop_sat", {24'b0, drop_count_s}, 32'd0);
        check("t6_rst_wrreq", {31'b0, fifo_wrreq}, 32'd0);
        fifo_usedw = 12'd0;
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
